// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit that fronts the word-organised
// data RAM: RISC-V funct3 encodings, FSM state type, and request decode
// helpers used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP,
        ERR
    } lsu_state_t;

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Reserved encodings, plus the unsigned variants which have no store form.
    function automatic logic is_illegal(input logic       we,
                                        input logic [2:0] funct3);
        logic ill;
        ill = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = we;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/lsu_ram_if.sv
// Bundle of the core-side request/response handshake and the RAM-side port.
// slave  : the load/store unit (consumes requests, drives the RAM)
// master : the environment (core + RAM) around it
interface lsu_ram_if #(
    parameter int unsigned AW = 10
);
    // core request
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    // core response
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    // RAM port
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data;
    logic          ram_wren;
    logic          ram_rden;
    logic [31:0]   ram_q;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_q,
        output req_ready, resp_valid, resp_err, resp_rdata,
               ram_address, ram_data, ram_wren, ram_rden
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_q,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               ram_address, ram_data, ram_wren, ram_rden
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte/half lane handling for a 32-bit word.
// Ports:
//   funct3    in  access size/signedness
//   offset    in  byte offset within the word (addr[1:0])
//   word      in  word read from RAM
//   wdata     in  right-justified store data
//   load_data out extracted and sign/zero-extended load value
//   merged    out word with the addressed byte/half replaced by wdata
//                 (wdata itself for a full-word access)
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[7:0];
        case (offset)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        sel_half = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = word;
                endcase
            end
            F3_H: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            F3_W:    merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu_ram.sv
// Load/store initiator for the 32-bit word RAM (combinational read,
// synchronous write). Byte-addressed RISC-V loads/stores are mapped onto
// word cycles: sub-word stores are read-modify-write, loads are lane
// extracted and extended, misaligned/illegal requests error out without
// touching memory.
// Ports:
//   clock    in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of lsu_ram_if (request, response, RAM port)
module lsu_ram
    import lsu_pkg::*;
#(
    parameter int unsigned mem_depth = 1024,
    parameter int unsigned size      = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    lsu_ram_if.slave   bus
);

    localparam int unsigned AW = $clog2(mem_depth);

    lsu_state_t      state;
    lsu_state_t      state_next;

    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [AW-1:0]   word_q;
    logic [size-1:0] wdata_q;
    logic [size-1:0] merge_q;
    logic [size-1:0] rdata_q;

    logic [31:0]     lane_load;
    logic [31:0]     lane_merged;
    logic            accept;
    logic            bad_req;

    // Byte address bits above the word index wrap modulo mem_depth.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:AW+2];

    assign accept  = (state == IDLE) && bus.req_valid;
    assign bad_req = is_misaligned(bus.req_funct3, bus.req_addr[1:0]) ||
                     is_illegal(bus.req_we, bus.req_funct3);

    lsu_lane u_lane (
        .funct3    (f3_q),
        .offset    (off_q),
        .word      (bus.ram_q),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                off_q   <= bus.req_addr[1:0];
                word_q  <= bus.req_addr[AW+1:2];
                wdata_q <= bus.req_wdata;
                // Cleared so stores and errors report zero read data.
                rdata_q <= '0;
            end
            if (state == RD)     rdata_q <= lane_load;
            if (state == RMW_RD) merge_q <= lane_merged;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bad_req)            state_next = ERR;
                    else if (!bus.req_we)   state_next = RD;
                    else if (bus.req_funct3 == F3_W) state_next = WR;
                    else                    state_next = RMW_RD;
                end
            end
            RD:      state_next = RESP;
            RMW_RD:  state_next = WR;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.resp_valid  = (state == RESP) || (state == ERR);
        bus.resp_err    = (state == ERR);
        bus.resp_rdata  = rdata_q;
        bus.ram_address = word_q;
        bus.ram_rden    = (state == RD) || (state == RMW_RD);
        bus.ram_wren    = (state == WR);
        bus.ram_data    = '0;
        if (state == WR) begin
            bus.ram_data = (f3_q == F3_W) ? wdata_q : merge_q;
        end
    end

endmodule

// File: tb/tb_lsu_ram.sv
// Directed bench for lsu_ram with a behavioural word RAM and a backdoor
// write port used to preload words while the unit is idle.
module tb_lsu_ram;
    import lsu_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    lsu_ram_if #(.AW(10)) bus ();

    lsu_ram #(.mem_depth(1024), .size(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:1023];
    logic        bd_we   = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clock) begin
        if (bus.ram_wren)  mem[bus.ram_address] <= bus.ram_data;
        else if (bd_we)    mem[bd_addr] <= bd_data;
    end
    assign bus.ram_q = mem[bus.ram_address];

    int unsigned wren_total = 0;
    always @(posedge clock) if (bus.ram_wren) wren_total <= wren_total + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clock);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clock);
        bd_we = 1'b0;
    endtask

    // Issues one request and watches cycles 1..8 after the accept edge.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rd, output logic er,
                          output int nw, output int nr, output logic [31:0] wdat);
        int k;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        cyc = -1; rd = '0; er = 1'b0; nw = 0; nr = 0; wdat = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (bus.ram_wren) begin nw++; wdat = bus.ram_data; end
            if (bus.ram_rden) nr++;
            if (bus.resp_valid) begin
                cyc = c; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, nw, nr;
        logic [31:0] rd, wdat;
        logic        er;
        int unsigned w0;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_ready",  bus.req_ready, 1);
        chk("rst_rvalid", bus.resp_valid, 0);
        chk("rst_err",    bus.resp_err, 0);
        chk("rst_rdata",  bus.resp_rdata, 0);
        chk("rst_wren",   bus.ram_wren, 0);
        chk("rst_rden",   bus.ram_rden, 0);
        chk("rst_addr",   bus.ram_address, 0);
        chk("rst_data",   bus.ram_data, 0);
        reset_n = 1'b1;

        // LW
        poke(10'd4, 32'hDEADBEEF);
        do_req(1'b0, F3_W, 32'h10, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("lw_cyc", cyc, 2); chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_err", er, 0);  chk("lw_wren", nw, 0); chk("lw_rden", nr, 1);

        // Lane extraction
        poke(10'd4, 32'h80FF7F01);
        do_req(1'b0, F3_B,  32'h13, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("lb13", rd, 32'hFFFFFF80); chk("lb13_cyc", cyc, 2);
        do_req(1'b0, F3_BU, 32'h13, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("lbu13", rd, 32'h00000080);
        do_req(1'b0, F3_B,  32'h11, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("lb11", rd, 32'h0000007F);
        do_req(1'b0, F3_BU, 32'h12, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("lbu12", rd, 32'h000000FF);
        do_req(1'b0, F3_H,  32'h12, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("lh12", rd, 32'hFFFF80FF);
        do_req(1'b0, F3_HU, 32'h10, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("lhu10", rd, 32'h00007F01);

        // SB read-modify-write
        poke(10'd4, 32'h11223344);
        do_req(1'b1, F3_B, 32'h11, 32'h000000AB, cyc, rd, er, nw, nr, wdat);
        chk("sb_cyc", cyc, 3);   chk("sb_wren", nw, 1); chk("sb_rden", nr, 1);
        chk("sb_wdata", wdat, 32'h1122AB44);
        chk("sb_err", er, 0);    chk("sb_rdata", rd, 0);
        do_req(1'b0, F3_W, 32'h10, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("sb_readback", rd, 32'h1122AB44);

        // SH upper half
        do_req(1'b1, F3_H, 32'h12, 32'h0000BEEF, cyc, rd, er, nw, nr, wdat);
        chk("sh_cyc", cyc, 3); chk("sh_wdata", wdat, 32'hBEEFAB44);
        chk("sh_mem", mem[4], 32'hBEEFAB44);

        // Misaligned / illegal
        do_req(1'b1, F3_H, 32'h13, 32'h00001234, cyc, rd, er, nw, nr, wdat);
        chk("mis_sh_cyc", cyc, 1); chk("mis_sh_err", er, 1);
        chk("mis_sh_rdata", rd, 0); chk("mis_sh_wren", nw, 0);
        chk("mis_sh_rden", nr, 0);  chk("mis_sh_mem", mem[4], 32'hBEEFAB44);
        do_req(1'b0, F3_W, 32'h02, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("mis_lw_err", er, 1); chk("mis_lw_cyc", cyc, 1);
        do_req(1'b0, F3_HU, 32'h11, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("mis_lhu_err", er, 1);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("ill_f3_err", er, 1); chk("ill_f3_rden", nr, 0);
        do_req(1'b1, F3_BU, 32'h10, 32'h55, cyc, rd, er, nw, nr, wdat);
        chk("ill_sbu_err", er, 1); chk("ill_sbu_wren", nw, 0);
        chk("ill_sbu_mem", mem[4], 32'hBEEFAB44);

        // Upper address bits ignored
        do_req(1'b1, F3_W, 32'h1000_0004, 32'h12345678, cyc, rd, er, nw, nr, wdat);
        chk("wrap_cyc", cyc, 2); chk("wrap_wren", nw, 1);
        chk("wrap_mem", mem[1], 32'h12345678);
        do_req(1'b0, F3_W, 32'h0000_1004, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("wrap_rd", rd, 32'h12345678);

        // Reset during RMW_RD
        poke(10'd8, 32'hCAFEF00D);
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H;
        bus.req_addr = 32'h22; bus.req_wdata = 32'h0000BEEF;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        chk("rmw_rden", bus.ram_rden, 1);
        chk("rmw_addr", bus.ram_address, 8);
        w0 = wren_total;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", bus.req_ready, 1);
        chk("arst_rden",  bus.ram_rden, 0);
        chk("arst_wren",  bus.ram_wren, 0);
        chk("arst_addr",  bus.ram_address, 0);
        chk("arst_rvalid", bus.resp_valid, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("arst_nowrite", wren_total, w0);
        chk("arst_mem8", mem[8], 32'hCAFEF00D);
        do_req(1'b0, F3_W, 32'h20, 32'h0, cyc, rd, er, nw, nr, wdat);
        chk("arst_after_cyc", cyc, 2); chk("arst_after_rd", rd, 32'hCAFEF00D);

        // Back-to-back with req_valid held high
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h1;
        @(posedge clock);
        #1 bus.req_we = 1'b0; bus.req_wdata = 32'h0;
        @(negedge clock);
        chk("b2b_c1_ready", bus.req_ready, 0);
        chk("b2b_c1_wren", bus.ram_wren, 1);
        @(negedge clock);
        chk("b2b_c2_resp", bus.resp_valid, 1);
        chk("b2b_c2_ready", bus.req_ready, 0);
        @(negedge clock);
        chk("b2b_c3_ready", bus.req_ready, 1);
        chk("b2b_c3_resp", bus.resp_valid, 0);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        chk("b2b_c4_rden", bus.ram_rden, 1);
        @(negedge clock);
        chk("b2b_c5_resp", bus.resp_valid, 1);
        chk("b2b_c5_rdata", bus.resp_rdata, 32'h00000001);
        chk("b2b_c5_err", bus.resp_err, 0);
        chk("b2b_mem0", mem[0], 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
